// File: rtl/modexp_ctrl_pkg.sv
// Shared types and helpers for the ModExp session sequencer.
// Holds the FSM state encoding, rtMod pass selectors and the limb-count helper.
package modexp_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCalcT,
        StCalcR,
        StCalcN0,
        StSend,
        StWaitCore,
        StRead
    } state_e;

    localparam logic MODE_T = 1'b0;
    localparam logic MODE_R = 1'b1;

    function automatic int unsigned limbs(input int unsigned op_width,
                                          input int unsigned limb_width);
        return op_width / limb_width;
    endfunction

endpackage

// File: rtl/modexp_session_ctrl_if.sv
// Host-side request/response handshake of the ModExp session sequencer.
// The host drives the master modport; the sequencer sits on the slave modport.
interface modexp_session_ctrl_if #(
    parameter int unsigned OP_WIDTH = 4096
);
    logic                start;
    logic [OP_WIDTH-1:0] message;
    logic [OP_WIDTH-1:0] exponent;
    logic [OP_WIDTH-1:0] modulus;
    logic                busy;
    logic                done;
    logic                error;
    logic [OP_WIDTH-1:0] result;

    modport master (
        output start, message, exponent, modulus,
        input  busy, done, error, result
    );

    modport slave (
        input  start, message, exponent, modulus,
        output busy, done, error, result
    );
endinterface

// File: rtl/limb_serializer.sv
// Shared limb index for SEND and READ: slices five operands onto the core buses
// and gathers result limbs; res_word already merges the limb arriving this cycle.
module limb_serializer
    import modexp_ctrl_pkg::*;
#(
    parameter int unsigned OP_WIDTH   = 4096,
    parameter int unsigned LIMB_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  send,
    input  logic                  recv,
    input  logic [OP_WIDTH-1:0]   m_op,
    input  logic [OP_WIDTH-1:0]   e_op,
    input  logic [OP_WIDTH-1:0]   n_op,
    input  logic [OP_WIDTH-1:0]   r_op,
    input  logic [OP_WIDTH-1:0]   t_op,
    input  logic [LIMB_WIDTH-1:0] res_out,
    output logic [LIMB_WIDTH-1:0] m_buf,
    output logic [LIMB_WIDTH-1:0] e_buf,
    output logic [LIMB_WIDTH-1:0] n_buf,
    output logic [LIMB_WIDTH-1:0] r_buf,
    output logic [LIMB_WIDTH-1:0] t_buf,
    output logic                  last,
    output logic [OP_WIDTH-1:0]   res_word
);
    localparam int unsigned NUM_LIMBS = limbs(OP_WIDTH, LIMB_WIDTH);
    localparam int unsigned IDX_W     = (NUM_LIMBS > 1) ? $clog2(NUM_LIMBS) : 1;

    logic [IDX_W-1:0]    idx_q;
    logic [OP_WIDTH-1:0] acc_q;
    int unsigned         base;

    assign base = 32'(idx_q) * LIMB_WIDTH;
    assign last = (idx_q == IDX_W'(NUM_LIMBS - 1));

    always_ff @(posedge clk) begin
        if (reset || !(send || recv) || last) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else if (recv) begin
            acc_q[base +: LIMB_WIDTH] <= res_out;
        end
    end

    always_comb begin
        m_buf    = '0;
        e_buf    = '0;
        n_buf    = '0;
        r_buf    = '0;
        t_buf    = '0;
        res_word = acc_q;
        res_word[base +: LIMB_WIDTH] = res_out;
        if (send) begin
            m_buf = m_op[base +: LIMB_WIDTH];
            e_buf = e_op[base +: LIMB_WIDTH];
            n_buf = n_op[base +: LIMB_WIDTH];
            r_buf = r_op[base +: LIMB_WIDTH];
            t_buf = t_op[base +: LIMB_WIDTH];
        end
    end

endmodule

// File: rtl/modexp_session_ctrl.sv
// Host-side ModExp sequencer: precompute (skipped on a modulus-cache hit),
// limb streaming to the core, result collection, and per-phase timeouts.
module modexp_session_ctrl
    import modexp_ctrl_pkg::*;
#(
    parameter int unsigned OP_WIDTH       = 4096,
    parameter int unsigned LIMB_WIDTH     = 64,
    parameter int unsigned TIMEOUT_CYCLES = 2**20
) (
    input  logic                  clk,
    input  logic                  reset,
    modexp_session_ctrl_if.slave  host,
    output logic                  pre_go,
    output logic                  pre_mode,
    input  logic [OP_WIDTH-1:0]   pre_r,
    input  logic                  pre_done,
    output logic                  inv_go,
    input  logic [LIMB_WIDTH-1:0] inv_result,
    input  logic                  inv_valid,
    output logic [LIMB_WIDTH-1:0] m_buf,
    output logic [LIMB_WIDTH-1:0] e_buf,
    output logic [LIMB_WIDTH-1:0] n_buf,
    output logic [LIMB_WIDTH-1:0] r_buf,
    output logic [LIMB_WIDTH-1:0] t_buf,
    output logic [LIMB_WIDTH-1:0] nprime0,
    output logic                  start_input,
    output logic                  start_compute,
    output logic                  get_result,
    input  logic                  core_complete,
    input  logic [LIMB_WIDTH-1:0] res_out
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [OP_WIDTH-1:0] m_q, e_q, n_q, t_q, r_q, cached_n_q, result_q;
    logic [LIMB_WIDTH-1:0] nprime0_q;
    logic                cache_valid_q, done_q, error_q;
    logic                first, expired, waiting, pre_take, timeout, last;
    logic [OP_WIDTH-1:0] res_word;

    assign first    = (cnt_q == '0);
    assign expired  = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    // The go-pulse cycle of each rtMod pass never counts as completion.
    assign pre_take = pre_done && !first;
    assign waiting  = (state_q == StCalcT) || (state_q == StCalcR) ||
                      (state_q == StCalcN0) || (state_q == StWaitCore);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Completion is tested before expiry so a same-cycle completion wins.
    always_comb begin
        state_d = state_q;
        timeout = 1'b0;
        case (state_q)
            StIdle: begin
                if (host.start) begin
                    state_d = (cache_valid_q && host.modulus == cached_n_q) ? StSend : StCalcT;
                end
            end
            StCalcT: begin
                if (pre_take) state_d = StCalcR;
                else if (expired) begin
                    timeout = 1'b1;
                    state_d = StIdle;
                end
            end
            StCalcR: begin
                if (pre_take) state_d = StCalcN0;
                else if (expired) begin
                    timeout = 1'b1;
                    state_d = StIdle;
                end
            end
            StCalcN0: begin
                if (inv_valid) state_d = StSend;
                else if (expired) begin
                    timeout = 1'b1;
                    state_d = StIdle;
                end
            end
            StSend:  if (last) state_d = StWaitCore;
            StWaitCore: begin
                if (core_complete) state_d = StRead;
                else if (expired) begin
                    timeout = 1'b1;
                    state_d = StIdle;
                end
            end
            StRead:  if (last) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        pre_go        = 1'b0;
        pre_mode      = MODE_T;
        inv_go        = 1'b0;
        start_input   = 1'b0;
        start_compute = 1'b0;
        get_result    = 1'b0;
        case (state_q)
            StCalcT:    pre_go = first;
            StCalcR: begin
                pre_go   = first;
                pre_mode = MODE_R;
            end
            StCalcN0:   inv_go = first;
            StSend:     start_input = 1'b1;
            StWaitCore: start_compute = first;
            StRead:     get_result = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || !waiting || state_d != state_q) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m_q           <= '0;
            e_q           <= '0;
            n_q           <= '0;
            t_q           <= '0;
            r_q           <= '0;
            cached_n_q    <= '0;
            cache_valid_q <= 1'b0;
            nprime0_q     <= '0;
            result_q      <= '0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            error_q <= timeout;
            if (state_q == StIdle && host.start) begin
                m_q <= host.message;
                e_q <= host.exponent;
                n_q <= host.modulus;
            end
            if (state_q == StCalcT && pre_take) t_q <= pre_r;
            if (state_q == StCalcR && pre_take) r_q <= pre_r;
            if (state_q == StCalcN0 && inv_valid) begin
                nprime0_q     <= inv_result;
                cached_n_q    <= n_q;
                cache_valid_q <= 1'b1;
            end
            if (timeout) cache_valid_q <= 1'b0;
            if (state_q == StRead && last) begin
                result_q <= res_word;
                done_q   <= 1'b1;
            end
        end
    end

    limb_serializer #(
        .OP_WIDTH  (OP_WIDTH),
        .LIMB_WIDTH(LIMB_WIDTH)
    ) u_limb_serializer (
        .clk     (clk),
        .reset   (reset),
        .send    (start_input),
        .recv    (get_result),
        .m_op    (m_q),
        .e_op    (e_q),
        .n_op    (n_q),
        .r_op    (r_q),
        .t_op    (t_q),
        .res_out (res_out),
        .m_buf   (m_buf),
        .e_buf   (e_buf),
        .n_buf   (n_buf),
        .r_buf   (r_buf),
        .t_buf   (t_buf),
        .last    (last),
        .res_word(res_word)
    );

    assign host.busy   = (state_q != StIdle);
    assign host.done   = done_q;
    assign host.error  = error_q;
    assign host.result = result_q;
    assign nprime0     = nprime0_q;

endmodule

// File: tb/tb_modexp_session_ctrl.sv
// Randomised bench for modexp_session_ctrl with behavioural rtMod, modInv and
// core models; expectations come from plain modular arithmetic and a cache model.
module tb_modexp_session_ctrl;
    import modexp_ctrl_pkg::*;

    localparam int unsigned OPW = 256;
    localparam int unsigned LW  = 64;
    localparam int unsigned NL  = 4;
    localparam int unsigned TMO = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    modexp_session_ctrl_if #(.OP_WIDTH(OPW)) host ();

    logic           pre_go, pre_mode, pre_done, pre_done_m, stray_pre;
    logic [OPW-1:0] pre_r;
    logic           inv_go, inv_valid;
    logic [LW-1:0]  inv_result;
    logic [LW-1:0]  m_buf, e_buf, n_buf, r_buf, t_buf, nprime0, res_out;
    logic           start_input, start_compute, get_result, core_complete;

    assign pre_done = pre_done_m | stray_pre;

    modexp_session_ctrl #(
        .OP_WIDTH      (OPW),
        .LIMB_WIDTH    (LW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .host         (host),
        .pre_go       (pre_go),
        .pre_mode     (pre_mode),
        .pre_r        (pre_r),
        .pre_done     (pre_done),
        .inv_go       (inv_go),
        .inv_result   (inv_result),
        .inv_valid    (inv_valid),
        .m_buf        (m_buf),
        .e_buf        (e_buf),
        .n_buf        (n_buf),
        .r_buf        (r_buf),
        .t_buf        (t_buf),
        .nprime0      (nprime0),
        .start_input  (start_input),
        .start_compute(start_compute),
        .get_result   (get_result),
        .core_complete(core_complete),
        .res_out      (res_out)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [OPW-1:0] got,
                            input logic [OPW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [OPW-1:0] t_fn(input logic [OPW-1:0] n);
        return n ^ {4{64'hA5A5_5A5A_0F0F_F0F0}};
    endfunction

    function automatic logic [OPW-1:0] r_fn(input logic [OPW-1:0] n);
        return {n[OPW-9:0], 8'h3C} + {64'd7, 64'd5, 64'd3, 64'd1};
    endfunction

    function automatic logic [LW-1:0] inv_fn(input logic [OPW-1:0] n);
        return n[LW-1:0] * 64'h9E37_79B9_7F4A_7C15 + 64'd1;
    endfunction

    function automatic longint unsigned modexp(input longint unsigned m, e, n);
        longint unsigned r, b, x;
        if (n == 0) return 0;
        r = 1 % n;
        b = m % n;
        x = e;
        while (x != 0) begin
            if (x[0]) r = (r * b) % n;
            b = (b * b) % n;
            x = x >> 1;
        end
        return r;
    endfunction

    // Operands of the request in flight, shared with the behavioural models.
    logic [OPW-1:0] cur_m, cur_e, cur_n;
    bit             core_hang;

    // rtMod model: random latency, result depends on the pass and the modulus.
    initial begin
        int   wait_n;
        logic mode;
        wait_n = 0;
        mode = 1'b0;
        pre_done_m = 1'b0;
        pre_r = '0;
        forever begin
            @(negedge clk);
            pre_done_m = 1'b0;
            if (reset) wait_n = 0;
            else if (pre_go) begin
                mode = pre_mode;
                wait_n = $urandom_range(1, 4);
            end else if (wait_n > 0) begin
                wait_n--;
                if (wait_n == 0) begin
                    pre_done_m = 1'b1;
                    pre_r = mode ? r_fn(cur_n) : t_fn(cur_n);
                end
            end
        end
    end

    initial begin
        int wait_n;
        wait_n = 0;
        inv_valid = 1'b0;
        inv_result = '0;
        forever begin
            @(negedge clk);
            inv_valid = 1'b0;
            if (reset) wait_n = 0;
            else if (inv_go) wait_n = $urandom_range(1, 3);
            else if (wait_n > 0) begin
                wait_n--;
                if (wait_n == 0) begin
                    inv_valid = 1'b1;
                    inv_result = inv_fn(cur_n);
                end
            end
        end
    end

    // Core model: captures streamed limbs and computes m^e mod n from them.
    logic [OPW-1:0] cap_m, cap_e, cap_n, cap_r, cap_t;
    logic [LW-1:0]  cap_np;
    int             cap_cnt;
    initial begin
        logic [OPW-1:0] cm, ce, cn, cr, ct, res;
        logic [LW-1:0]  cnp;
        int sidx, ridx, wait_n;
        {cm, ce, cn, cr, ct, res} = '0;
        cnp = '0;
        sidx = 0;
        ridx = 0;
        wait_n = 0;
        core_complete = 1'b0;
        res_out = '0;
        forever begin
            @(negedge clk);
            core_complete = 1'b0;
            if (reset) begin
                sidx = 0;
                wait_n = 0;
            end else begin
                if (start_input && sidx < NL) begin
                    cm[sidx*LW +: LW] = m_buf;
                    ce[sidx*LW +: LW] = e_buf;
                    cn[sidx*LW +: LW] = n_buf;
                    cr[sidx*LW +: LW] = r_buf;
                    ct[sidx*LW +: LW] = t_buf;
                    cnp = nprime0;
                    sidx++;
                end
                if (start_compute) begin
                    {cap_m, cap_e, cap_n, cap_r, cap_t} = {cm, ce, cn, cr, ct};
                    cap_np = cnp;
                    cap_cnt = sidx;
                    sidx = 0;
                    ridx = 0;
                    res = '0;
                    res[63:0] = modexp(cm[63:0], ce[63:0], cn[63:0]);
                    wait_n = core_hang ? 0 : $urandom_range(1, 5);
                end else if (wait_n > 0) begin
                    wait_n--;
                    if (wait_n == 0) core_complete = 1'b1;
                end
                if (get_result && ridx < NL) begin
                    res_out = res[ridx*LW +: LW];
                    ridx++;
                end
            end
        end
    end

    int   cyc = 0, inv_cnt = 0, si_cnt = 0, done_cnt = 0, err_cnt = 0, sc_cyc = 0, err_cyc = 0;
    logic pre_modes[$];
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                if (pre_go) pre_modes.push_back(pre_mode);
                if (inv_go) inv_cnt++;
                if (start_input) si_cnt++;
                if (host.done) done_cnt++;
                if (host.error) begin
                    err_cnt++;
                    err_cyc = cyc;
                end
                if (start_compute) sc_cyc = cyc;
            end
        end
    end

    // Reference cache and last-good-result model.
    bit             cache_ok = 0;
    logic [OPW-1:0] cached_n = '0;
    logic [OPW-1:0] exp_prev = '0;
    int pre_base, inv_base, si_base, done_base, err_base;

    task automatic snapshot();
        pre_base = pre_modes.size();
        inv_base = inv_cnt;
        si_base = si_cnt;
        done_base = done_cnt;
        err_base = err_cnt;
    endtask

    task automatic issue(input longint unsigned m, e, n);
        cur_m = OPW'(m);
        cur_e = OPW'(e);
        cur_n = OPW'(n);
        @(negedge clk);
        host.start = 1'b1;
        host.message = cur_m;
        host.exponent = cur_e;
        host.modulus = cur_n;
        @(negedge clk);
        host.start = 1'b0;
        host.message = '1;
        host.exponent = '1;
        host.modulus = '1;
        check_eq("busy_on_accept", host.busy, 1);
    endtask

    task automatic run_op(input longint unsigned m, e, n, input bit hang, input bit poke);
        bit hit, poked;
        int k;
        logic [OPW-1:0] exp_res;
        hit = cache_ok && (cached_n == OPW'(n));
        core_hang = hang;
        poked = 0;
        snapshot();
        issue(m, e, n);
        k = 0;
        while (!(host.done || host.error) && k < 300) begin
            @(negedge clk);
            k++;
            if (poke && get_result && !poked) begin
                host.start = 1'b1;
                poked = 1;
            end else begin
                host.start = 1'b0;
            end
        end
        host.start = 1'b0;
        #1;
        check_eq("op_completes", k < 300, 1);
        check_eq("busy_after", host.busy, 0);
        exp_res = OPW'(modexp(m, e, n));
        if (hang) begin
            check_eq("err_latency", err_cyc - sc_cyc, TMO);
            check_eq("result_held", host.result, exp_prev);
            cache_ok = 0;
        end else begin
            check_eq("result", host.result, exp_res);
            exp_prev = exp_res;
            cache_ok = 1;
            cached_n = OPW'(n);
        end
        check_eq("core_m", cap_m, cur_m);
        check_eq("core_e", cap_e, cur_e);
        check_eq("core_n", cap_n, cur_n);
        check_eq("core_t", cap_t, t_fn(cur_n));
        check_eq("core_r", cap_r, r_fn(cur_n));
        check_eq("core_nprime0", cap_np, inv_fn(cur_n));
        check_eq("limbs_sent", cap_cnt, NL);
        repeat (3) @(negedge clk);
        #1;
        check_eq("done_pulses", done_cnt - done_base, hang ? 0 : 1);
        check_eq("err_pulses", err_cnt - err_base, hang ? 1 : 0);
        check_eq("pre_go_pulses", pre_modes.size() - pre_base, hit ? 0 : 2);
        if (!hit && pre_modes.size() - pre_base == 2) begin
            check_eq("pre_mode_first", pre_modes[pre_base], MODE_T);
            check_eq("pre_mode_second", pre_modes[pre_base + 1], MODE_R);
        end
        check_eq("inv_go_pulses", inv_cnt - inv_base, hit ? 0 : 1);
        check_eq("start_input_cycles", si_cnt - si_base, NL);
    endtask

    task automatic reset_in_send(input longint unsigned m, e, n);
        int seen, k;
        core_hang = 0;
        issue(m, e, n);
        seen = 0;
        k = 0;
        while (k < 100) begin
            if (start_input) seen++;
            if (seen == 3) break;
            @(negedge clk);
            k++;
        end
        check_eq("reached_limb2", seen, 3);
        reset = 1'b1;
        @(negedge clk);
        check_eq("abort_result", host.result, 0);
        check_eq("abort_outs_zero", |{host.busy, host.done, host.error, pre_go, pre_mode, inv_go,
                 m_buf, e_buf, n_buf, r_buf, t_buf, nprime0, start_input, start_compute,
                 get_result}, 0);
        @(negedge clk);
        reset = 1'b0;
        cache_ok = 0;
        exp_prev = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        longint unsigned rn, rm, re;
        int sel;
        reset = 1'b1;
        stray_pre = 1'b0;
        core_hang = 0;
        host.start = 1'b0;
        host.message = '0;
        host.exponent = '0;
        host.modulus = '0;
        cur_m = '0;
        cur_e = '0;
        cur_n = '0;
        repeat (2) @(negedge clk);
        check_eq("reset_result", host.result, 0);
        check_eq("reset_outs_zero", |{host.busy, host.done, host.error, pre_go, pre_mode, inv_go,
                 m_buf, e_buf, n_buf, r_buf, t_buf, nprime0, start_input, start_compute,
                 get_result}, 0);
        reset = 1'b0;

        run_op(8, 13, 77, 0, 0);
        check_eq("result_8_13_77", host.result, 50);
        run_op(2, 10, 77, 0, 0);
        check_eq("result_2_10_77", host.result, 23);
        run_op(3, 5, 91, 0, 0);
        check_eq("result_3_5_91", host.result, 61);
        check_eq("nprime0_updated", nprime0, inv_fn(OPW'(91)));
        run_op(4, 7, 91, 1, 0);
        check_eq("result_after_timeout", host.result, 61);
        run_op(5, 3, 91, 0, 0);
        reset_in_send(6, 5, 91);
        run_op(6, 5, 91, 0, 0);

        run_op(7, 3, 91, 0, 1);
        snapshot();
        @(negedge clk);
        stray_pre = 1'b1;
        @(negedge clk);
        stray_pre = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("stray_busy", host.busy, 0);
        check_eq("stray_pre_go", pre_modes.size() - pre_base, 0);
        check_eq("stray_done", done_cnt - done_base, 0);
        check_eq("stray_result", host.result, OPW'(modexp(7, 3, 91)));

        for (int i = 0; i < 12; i++) begin
            sel = $urandom_range(0, 2);
            rn = (sel == 0) ? 77 : (sel == 1) ? 91 : longint'($urandom_range(50, 32767)) * 2 + 1;
            rm = longint'($urandom_range(0, 32767)) % rn;
            re = longint'($urandom_range(1, 255));
            run_op(rm, re, rn, ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
